dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_LIMIT, default 32'h0008_0000, is the first byte address outside data memory (512 KB).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid[1:0]  input  2  per-requester request valid (index 0 = core LSU, 1 = loader/DMA).
REQ-005 req_ready[1:0]  output  2  per-requester accept strobe.
REQ-006 req_addr[1:0]  input  2x32  byte address per requester.
REQ-007 req_wdata[1:0]  input  2x32  store data per requester.
REQ-008 req_we[1:0]  input  2  1 = store, 0 = load.
REQ-009 req_funct3[1:0]  input  2x3  access type: 010 word, 100 byte-unsigned load, 000 byte store.
REQ-010 rsp_valid[1:0]  output  2  one-cycle response strobe per requester.
REQ-011 rsp_rdata  output  32  load data, shared by both requesters; qualified by rsp_valid.
REQ-012 rsp_err  output  1  error flag, shared by both requesters; qualified by rsp_valid.
REQ-013 mem_address, mem_write_data  output  32 each  memory address and store data.
REQ-014 mem_w_write_enable, mem_b_write_enable, mem_read_enable  output  1 each  memory word-write, byte-write and read strobes.
REQ-015 mem_funct3  output  3  memory access type.
REQ-016 mem_read_data  input  32  combinational memory read data.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-018 IDLE transitions:
- if any req_valid is high, the block SHALL assert req_ready for exactly one winner;
- it SHALL latch that winner's addr/wdata/we/funct3 and index;
- next state SHALL be ACCESS.
REQ-019 Arbitration SHALL be round-robin:
- priority pointer resets to 0;
- after each RESP the pointer SHALL point to the non-winner;
- a lone valid requester SHALL always win.
REQ-020 req_ready SHALL be low in ACCESS and RESP; a requester SHALL hold req_valid and its fields stable until it sees req_ready.
REQ-021 ACCESS SHALL drive the mem_* outputs from the latched request for exactly one cycle, register mem_read_data into rsp_rdata for loads, and go to RESP.
REQ-022 Access decoding:
- SW (we=1, 010) SHALL pulse mem_w_write_enable;
- SB (we=1, 000) SHALL pulse mem_b_write_enable;
- LW/LBU (we=0, 010/100) SHALL pulse mem_read_enable.
REQ-023 Error cases (no memory strobe; rsp_err=1; rsp_rdata=0):
- word access with addr[1:0] != 0;
- address >= ADDR_LIMIT;
- any other funct3/we combination.
REQ-024 RESP SHALL pulse rsp_valid[winner] for one cycle and return to IDLE.
REQ-025 Timing: acceptance in cycle N, memory strobe in cycle N+1, rsp_valid in cycle N+2, next acceptance no earlier than cycle N+3.
REQ-026 Outside ACCESS, all mem_* strobes SHALL be 0 and mem_address/mem_write_data/mem_funct3 SHALL be 0.
REQ-027 Stores SHALL return rsp_rdata=0.
REQ-028 rsp_rdata and rsp_err SHALL hold their values until the next RESP.

Reset
REQ-029 While rst_n is low:
- state SHALL be IDLE and the pointer 0;
- all outputs SHALL be 0, including req_ready, rsp_valid, rsp_rdata, rsp_err and every mem_* output.
REQ-030 Reset asserted during ACCESS or RESP SHALL abort the transaction, with no strobe after reset and no response.

Structure
REQ-031 Package mem_pkg SHALL hold:
- the state enum;
- funct3 constants (FUNCT3_W, FUNCT3_BU, FUNCT3_B);
- the ADDR_LIMIT default.
REQ-032 The round-robin grant logic SHALL be the sub-module rr_arbiter2 (valid[1:0], pointer -> one-hot grant).

Verification
REQ-033 Single load: req0 LW at 0x100, mem_read_data=0xDEADBEEF -> mem_read_enable high in N+1, rsp_valid[0] with rsp_rdata=0xDEADBEEF in N+2.
REQ-034 Contention: both valid continuously, starting from reset -> grants 0,1,0,1 in order, with one grant every 3 cycles.
REQ-035 Byte store: req1 SB at 0x203 with wdata 0xAB -> mem_b_write_enable, mem_address=0x203, mem_funct3=000 for one cycle; rsp_err=0.
REQ-036 Errors: SW at 0x102, LW at 0x0008_0000, and funct3=001 -> no mem strobe, rsp_err=1, rsp_rdata=0.
REQ-037 Reset mid-ACCESS: rst_n low during the strobe cycle -> all outputs 0 immediately and no rsp_valid; after release, the pointer is back at 0.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types, access constants and decode helper for the data-memory arbiter
package mem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic [1:0] {ACC_ERR, ACC_SW, ACC_SB, ACC_LD} acc_e;
  localparam logic [2:0] FUNCT3_W = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_B = 3'b000;
  localparam logic [31:0] ADDR_LIMIT_DEFAULT = 32'h0008_0000;
  function automatic acc_e decode(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] limit);
    if (addr >= limit) return ACC_ERR;
    if (f3 == FUNCT3_W) return addr[1:0] != 2'b00 ? ACC_ERR : we ? ACC_SW : ACC_LD;
    if (we && f3 == FUNCT3_B) return ACC_SB;
    if (!we && f3 == FUNCT3_BU) return ACC_LD;
    return ACC_ERR;
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: two-requester request/response bundle for the data-memory arbiter
interface dmem_arbiter_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][2:0] req_funct3;
  logic [1:0] rsp_valid;
  logic [31:0] rsp_rdata;
  logic rsp_err;
  modport master(output req_valid, req_we, req_addr, req_wdata, req_funct3, input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave(input req_valid, req_we, req_addr, req_wdata, req_funct3, output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; ptr names the favoured requester when both are valid
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);
  assign grant[0] = valid[0] & (~ptr | ~valid[1]);
  assign grant[1] = valid[1] & (ptr | ~valid[0]);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises two requesters onto one data memory, one access per three cycles
module dmem_arbiter import mem_pkg::*; #(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_arbiter_if.slave bus,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_w_write_enable,
  output logic        mem_b_write_enable,
  output logic        mem_read_enable,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_read_data
);
  state_e state, state_nx;
  logic ptr, win, act;
  logic [1:0] grant;
  logic [31:0] addr_q, wdata_q;
  logic we_q;
  logic [2:0] f3_q;
  acc_e acc;
  rr_arbiter2 u_rr (.valid(bus.req_valid), .ptr(ptr), .grant(grant));
  assign acc = decode(we_q, f3_q, addr_q, ADDR_LIMIT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 1'b0;
      win <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      f3_q <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |grant) begin
        win <= grant[1];
        addr_q <= bus.req_addr[grant[1]];
        wdata_q <= bus.req_wdata[grant[1]];
        we_q <= bus.req_we[grant[1]];
        f3_q <= bus.req_funct3[grant[1]];
      end
      if (state == ACCESS) begin
        bus.rsp_rdata <= acc == ACC_LD ? mem_read_data : '0;
        bus.rsp_err <= acc == ACC_ERR;
      end
      if (state == RESP) ptr <= ~win;
    end
  end
  // req_ready is gated by rst_n so nothing is accepted while reset is held
  always_comb begin
    state_nx = state == IDLE ? (|bus.req_valid ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
    act = state == ACCESS;
    bus.req_ready = (state == IDLE && rst_n) ? grant : 2'b00;
    bus.rsp_valid = state == RESP ? (win ? 2'b10 : 2'b01) : 2'b00;
    mem_address = act ? addr_q : '0;
    mem_write_data = act ? wdata_q : '0;
    mem_funct3 = act ? f3_q : '0;
    mem_w_write_enable = act && acc == ACC_SW;
    mem_b_write_enable = act && acc == ACC_SB;
    mem_read_enable = act && acc == ACC_LD;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random transactions against a transaction-level arbiter model
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic mem_w_write_enable, mem_b_write_enable, mem_read_enable;
  logic [2:0] mem_funct3;
  int checks = 0;
  int errors = 0;
  logic [1:0] pending;
  logic [31:0] f_addr[2], f_wdata[2];
  logic f_we[2];
  logic [2:0] f_f3[2];
  logic ptr_m;
  logic [31:0] prev_rdata;
  logic prev_err;
  int last_w;

  dmem_arbiter_if bus();
  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_w_write_enable(mem_w_write_enable), .mem_b_write_enable(mem_b_write_enable),
    .mem_read_enable(mem_read_enable), .mem_funct3(mem_funct3), .mem_read_data(mem_read_data)
  );
  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a, input logic [2:0] f);
    logic [31:0] w;
    w = ({a[31:2], 2'b00} == 32'h100) ? 32'hDEADBEEF : ({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'h13572468;
    return f == 3'b100 ? (w >> (8 * a[1:0])) & 32'hFF : w;
  endfunction
  assign mem_read_data = memfn(mem_address, mem_funct3);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req_valid = pending;
    for (int i = 0; i < 2; i++) begin
      bus.req_addr[i] = f_addr[i];
      bus.req_wdata[i] = f_wdata[i];
      bus.req_we[i] = f_we[i];
      bus.req_funct3[i] = f_f3[i];
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    pending[i] = 1'b1;
    f_we[i] = we;
    f_f3[i] = f3;
    f_addr[i] = a;
    f_wdata[i] = d;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_strobes"}, {29'd0, mem_w_write_enable, mem_b_write_enable, mem_read_enable}, 32'd0);
    chk({tag, "_addr"}, mem_address, 32'd0);
    chk({tag, "_wdata"}, mem_write_data, 32'd0);
    chk({tag, "_funct3"}, {29'd0, mem_funct3}, 32'd0);
  endtask

  task automatic issue();
    int w;
    logic [1:0] oh;
    logic a_we, sw, sb, lw, lbu, err;
    logic [2:0] a_f3;
    logic [31:0] a, d, exp_rd;
    w = pending == 2'b11 ? int'(ptr_m) : int'(pending[1]);
    oh = w == 1 ? 2'b10 : 2'b01;
    a = f_addr[w];
    d = f_wdata[w];
    a_we = f_we[w];
    a_f3 = f_f3[w];
    sw = a_we && a_f3 == 3'b010 && a[1:0] == 2'b00;
    sb = a_we && a_f3 == 3'b000;
    lw = !a_we && a_f3 == 3'b010 && a[1:0] == 2'b00;
    lbu = !a_we && a_f3 == 3'b100;
    err = (a >= 32'h0008_0000) || !(sw || sb || lw || lbu);
    exp_rd = (err || a_we) ? 32'd0 : memfn(a, a_f3);
    drive();
    @(negedge clk);
    chk("idle_ready", {30'd0, bus.req_ready}, {30'd0, oh});
    chk("idle_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    chk("hold_rdata", bus.rsp_rdata, prev_rdata);
    chk("hold_err", {31'd0, bus.rsp_err}, {31'd0, prev_err});
    chk_quiet("idle");
    @(posedge clk); #1;
    pending[w] = 1'b0;
    drive();
    @(negedge clk);
    chk("acc_ready", {30'd0, bus.req_ready}, 32'd0);
    chk("acc_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    chk("acc_strobes", {29'd0, mem_w_write_enable, mem_b_write_enable, mem_read_enable},
        {29'd0, sw && !err, sb && !err, (lw || lbu) && !err});
    if (!err) begin
      chk("acc_addr", mem_address, a);
      chk("acc_wdata", mem_write_data, d);
      chk("acc_funct3", {29'd0, mem_funct3}, {29'd0, a_f3});
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, oh});
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, err});
    chk("rsp_ready", {30'd0, bus.req_ready}, 32'd0);
    chk_quiet("rsp");
    @(posedge clk); #1;
    ptr_m = (w == 0);
    last_w = w;
    prev_rdata = exp_rd;
    prev_err = err;
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return 32'($urandom_range(0, 4095));
    if (r == 1) return $urandom & 32'h0007_FFFF;
    if (r == 2) return 32'h0007_FFFC + 32'($urandom_range(0, 8));
    return $urandom;
  endfunction

  function automatic logic [2:0] rnd_f3();
    int r;
    r = $urandom_range(0, 4);
    return r == 0 ? 3'b010 : r == 1 ? 3'b100 : r == 2 ? 3'b000 : 3'($urandom_range(0, 7));
  endfunction

  initial begin
    pending = 2'b11;
    for (int i = 0; i < 2; i++) begin
      f_addr[i] = 32'h100;
      f_wdata[i] = 32'h1234_5678;
      f_we[i] = 1'b0;
      f_f3[i] = 3'b010;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {30'd0, bus.req_ready}, 32'd0);
    chk("reset_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    chk("reset_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_err", {31'd0, bus.rsp_err}, 32'd0);
    chk_quiet("reset");
    pending = 2'b00;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 1'b0;
    prev_rdata = 32'd0;
    prev_err = 1'b0;
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'b010, 32'h100, 32'd0);
    issue();
    chk("single_load_data", prev_rdata, 32'hDEADBEEF);
    set_req(1, 1'b1, 3'b000, 32'h203, 32'hAB);
    issue();
    set_req(0, 1'b1, 3'b010, 32'h102, 32'h55);
    issue();
    set_req(0, 1'b0, 3'b010, 32'h0008_0000, 32'd0);
    issue();
    set_req(0, 1'b0, 3'b001, 32'h200, 32'd0);
    issue();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 1'b0;
    prev_rdata = 32'd0;
    prev_err = 1'b0;
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'b010, 32'h300, 32'd0);
    set_req(1, 1'b0, 3'b100, 32'h305, 32'd0);
    for (int k = 0; k < 4; k++) begin
      issue();
      chk("contention_order", 32'(last_w), 32'(k % 2));
      if (last_w == 0) set_req(0, 1'b0, 3'b010, 32'h300 + 32'(4 * k), 32'd0);
      else set_req(1, 1'b0, 3'b100, 32'h305 + 32'(k), 32'd0);
    end
    pending = 2'b00;
    set_req(0, 1'b0, 3'b010, 32'h40, 32'd0);
    issue();
    set_req(1, 1'b0, 3'b010, 32'h44, 32'd0);
    drive();
    @(negedge clk);
    chk("abort_ready", {30'd0, bus.req_ready}, 32'd2);
    @(posedge clk); #1;
    pending = 2'b00;
    drive();
    chk("abort_pre_strobe", {31'd0, mem_read_enable}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ready0", {30'd0, bus.req_ready}, 32'd0);
    chk("abort_rsp_valid0", {30'd0, bus.rsp_valid}, 32'd0);
    chk("abort_rdata0", bus.rsp_rdata, 32'd0);
    chk("abort_err0", {31'd0, bus.rsp_err}, 32'd0);
    chk_quiet("abort");
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", {30'd0, bus.rsp_valid}, 32'd0);
      chk("abort_no_strobe", {29'd0, mem_w_write_enable, mem_b_write_enable, mem_read_enable}, 32'd0);
    end
    rst_n = 1'b1;
    ptr_m = 1'b0;
    prev_rdata = 32'd0;
    prev_err = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_abort_no_rsp", {30'd0, bus.rsp_valid}, 32'd0);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'b010, 32'h48, 32'd0);
    set_req(1, 1'b0, 3'b010, 32'h4C, 32'd0);
    issue();
    chk("abort_ptr_reset", 32'(last_w), 32'd0);
    issue();
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++)
        if (!pending[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), rnd_f3(), rnd_addr(), $urandom);
      if (pending == 2'b00) set_req(0, 1'($urandom_range(0, 1)), rnd_f3(), rnd_addr(), $urandom);
      issue();
    end
    while (pending != 2'b00) issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
